// File: rtl/id_ex_stage.sv
// ID/EX pipeline register and execute-operand front end of the RV32I core.
// Holds the decoded instruction for one cycle, resolves RAW hazards by
// forwarding from EX/MEM and WB, detects load-use hazards, and drives the ALU
// operand/opcode inputs combinationally so the ALU result is ready in EX.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  // decode slot
  input  logic            id_valid_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [XLEN-1:0] id_rs1_data_i,
  input  logic [XLEN-1:0] id_rs2_data_i,
  input  logic [RA_W-1:0] id_rs1_addr_i,
  input  logic [RA_W-1:0] id_rs2_addr_i,
  input  logic [RA_W-1:0] id_rd_addr_i,
  input  logic            id_uses_rs1_i,
  input  logic            id_uses_rs2_i,
  input  logic [XLEN-1:0] id_imm_i,
  input  logic [3:0]      id_alu_op_i,
  input  logic            id_src1_pc_i,
  input  logic            id_src2_imm_i,
  input  logic            id_reg_we_i,
  input  logic            id_mem_read_i,
  input  logic            id_mem_write_i,
  // pipeline control
  input  logic            stall_i,
  input  logic            flush_i,
  // forwarding sources
  input  logic [RA_W-1:0] exm_rd_addr_i,
  input  logic            exm_reg_we_i,
  input  logic [XLEN-1:0] exm_result_i,
  input  logic [RA_W-1:0] wb_rd_addr_i,
  input  logic            wb_reg_we_i,
  input  logic [XLEN-1:0] wb_data_i,
  // outputs
  output logic            load_use_stall_o,
  output logic            ex_valid_o,
  output logic [XLEN-1:0] alu_data1_o,
  output logic [XLEN-1:0] alu_data2_o,
  output logic [3:0]      alu_op_o,
  output logic [XLEN-1:0] ex_store_data_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [RA_W-1:0] ex_rd_addr_o,
  output logic            ex_reg_we_o,
  output logic            ex_mem_read_o,
  output logic            ex_mem_write_o
);

  // Everything the EX slot remembers about one instruction. An all-zero
  // value is exactly a bubble (valid=0, controls off, ADD opcode).
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rs1_addr;
    logic [RA_W-1:0] rs2_addr;
    logic [RA_W-1:0] rd_addr;
    logic [3:0]      alu_op;
    logic            src1_pc;
    logic            src2_imm;
    logic            reg_we;
    logic            mem_read;
    logic            mem_write;
  } ex_reg_t;

  ex_reg_t ex_q;
  ex_reg_t ex_d;

  // WB and EX/MEM match terms; a destination of x0 never matches.
  logic wb_live;
  logic exm_live;
  logic wb_hit_id1, wb_hit_id2;
  logic wb_hit_ex1, wb_hit_ex2;
  logic exm_hit_ex1, exm_hit_ex2;

  assign wb_live     = wb_reg_we_i  && (wb_rd_addr_i  != '0);
  assign exm_live    = exm_reg_we_i && (exm_rd_addr_i != '0);
  assign wb_hit_id1  = wb_live  && (wb_rd_addr_i  == id_rs1_addr_i);
  assign wb_hit_id2  = wb_live  && (wb_rd_addr_i  == id_rs2_addr_i);
  assign wb_hit_ex1  = wb_live  && (wb_rd_addr_i  == ex_q.rs1_addr);
  assign wb_hit_ex2  = wb_live  && (wb_rd_addr_i  == ex_q.rs2_addr);
  assign exm_hit_ex1 = exm_live && (exm_rd_addr_i == ex_q.rs1_addr);
  assign exm_hit_ex2 = exm_live && (exm_rd_addr_i == ex_q.rs2_addr);

  // A load in EX cannot forward its data yet; an ID consumer of it must wait.
  assign load_use_stall_o = id_valid_i && ex_q.valid && ex_q.mem_read &&
                            (ex_q.rd_addr != '0) &&
                            ((id_uses_rs1_i && (id_rs1_addr_i == ex_q.rd_addr)) ||
                             (id_uses_rs2_i && (id_rs2_addr_i == ex_q.rd_addr)));

  // Next EX slot contents: hold (with WB refresh), bubble, or capture.
  always_comb begin
    // NOTE: ex_d gets a full default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    ex_d = ex_q;
    if (stall_i) begin
      // A held instruction would miss a WB that retires during the stall,
      // so absorb it into the stored operand now.
      if (ex_q.valid && wb_hit_ex1) ex_d.rs1_data = wb_data_i;
      if (ex_q.valid && wb_hit_ex2) ex_d.rs2_data = wb_data_i;
    end else if (flush_i || load_use_stall_o) begin
      ex_d = '0;
    end else begin
      ex_d.valid     = id_valid_i;
      ex_d.pc        = id_pc_i;
      // Register file is written at the end of this cycle; take WB directly.
      ex_d.rs1_data  = wb_hit_id1 ? wb_data_i : id_rs1_data_i;
      ex_d.rs2_data  = wb_hit_id2 ? wb_data_i : id_rs2_data_i;
      ex_d.imm       = id_imm_i;
      ex_d.rs1_addr  = id_rs1_addr_i;
      ex_d.rs2_addr  = id_rs2_addr_i;
      ex_d.rd_addr   = id_rd_addr_i;
      ex_d.alu_op    = id_alu_op_i;
      ex_d.src1_pc   = id_src1_pc_i;
      ex_d.src2_imm  = id_src2_imm_i;
      ex_d.reg_we    = id_reg_we_i;
      ex_d.mem_read  = id_mem_read_i;
      ex_d.mem_write = id_mem_write_i;
    end
  end

  // EX slot register with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: state uses non-blocking assignment so every flop samples the
    // pre-edge values, independent of block ordering.
    if (!rst_n_i) ex_q <= '0;
    else          ex_q <= ex_d;
  end

  // Forwarded operands: x0 reads zero, then EX/MEM, then WB, then stored.
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  always_comb begin
    if (ex_q.rs1_addr == '0) fwd_rs1 = '0;
    else if (exm_hit_ex1)    fwd_rs1 = exm_result_i;
    else if (wb_hit_ex1)     fwd_rs1 = wb_data_i;
    else                     fwd_rs1 = ex_q.rs1_data;
  end

  always_comb begin
    if (ex_q.rs2_addr == '0) fwd_rs2 = '0;
    else if (exm_hit_ex2)    fwd_rs2 = exm_result_i;
    else if (wb_hit_ex2)     fwd_rs2 = wb_data_i;
    else                     fwd_rs2 = ex_q.rs2_data;
  end

  assign alu_data1_o     = ex_q.src1_pc  ? ex_q.pc  : fwd_rs1;
  assign alu_data2_o     = ex_q.src2_imm ? ex_q.imm : fwd_rs2;
  assign alu_op_o        = ex_q.alu_op;
  assign ex_store_data_o = fwd_rs2;
  assign ex_valid_o      = ex_q.valid;
  assign ex_pc_o         = ex_q.pc;
  assign ex_rd_addr_o    = ex_q.rd_addr;
  assign ex_reg_we_o     = ex_q.reg_we    && ex_q.valid;
  assign ex_mem_read_o   = ex_q.mem_read  && ex_q.valid;
  assign ex_mem_write_o  = ex_q.mem_write && ex_q.valid;

endmodule
